regfile_write_arbiter: RTL
==========================

Name: regfile_write_arbiter

Overview:
Shares the register file's single write port (RegWrite/RDaddr/RDdata) between two producers.
- Requester A: the pipeline writeback stage.
- Requester B: a long-latency unit (multi-cycle mul/div or load unit).
Also holds a pending-write scoreboard, so the hazard unit can stall consumers of registers whose B write has not yet landed. Sits between the WB stage / long-latency unit and the register file.

Parameters:
STARVE_LIMIT, 4, consecutive cycles B may be refused before it is forced through (1..15; only used with STARVE_EN).
CNT_W, 4, width of the starvation counter; must hold STARVE_LIMIT.

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous, active-high reset
a_valid_i  in  1  writeback request from pipeline
a_ready_o  out  1  A request accepted this cycle
a_addr_i  in  5  A destination register
a_data_i  in  32  A write data
b_valid_i  in  1  writeback request from long-latency unit
b_ready_o  out  1  B request accepted this cycle
b_addr_i  in  5  B destination register
b_data_i  in  32  B write data
mark_valid_i  in  1  issue of a B-producing instruction
mark_addr_i  in  5  its destination register
rs_addr_i  in  5  scoreboard lookup address (rs)
rt_addr_i  in  5  scoreboard lookup address (rt)
rs_busy_o  out  1  rs has a pending B write
rt_busy_o  out  1  rt has a pending B write
busy_vec_o  out  32  full scoreboard
RegWrite_o  out  1  register file write enable
RDaddr_o  out  5  register file write address
RDdata_o  out  32  register file write data

Behaviour:
Arbitration and handshake:
- Arbitration is combinational each cycle. force_b = STARVE_EN && b_valid_i && (wait_cnt == STARVE_LIMIT).
- grant_a = a_valid_i && !force_b.
- grant_b = b_valid_i && !grant_a.
- a_ready_o = !force_b; b_ready_o = grant_b. A handshake completes when valid && ready.
- Requesters hold addr/data stable while valid and not ready.

Write output stage (registered):
- On the edge after a grant: RegWrite_o <= (granted addr != 0); RDaddr_o and RDdata_o <= granted addr/data; out_from_b <= grant_b.
- No grant: RegWrite_o <= 0; RDaddr_o and RDdata_o hold their value.
- Latency from grant to write on the port: exactly 1 cycle. RegWrite_o is high for exactly one cycle per accepted nonzero-address request.
- Address 0: the handshake completes, but no port write is issued.

Starvation counter wait_cnt:
- Increments when b_valid_i && !grant_b, saturating at STARVE_LIMIT.
- Clears on grant_b or when !b_valid_i.

Scoreboard busy[31:0]:
- Set: mark_valid_i && mark_addr_i != 0 sets busy[mark_addr_i] at the edge.
- Clear: busy[RDaddr_o] clears at the edge ending a cycle in which RegWrite_o && out_from_b. The bit therefore stays high through the cycle the write is on the port.
- Same register set and cleared in the same cycle: set wins.
- busy[0] is always 0.
- A writes never modify the scoreboard. An A write to a busy register is permitted; the bit is unchanged.
- rs_busy_o = busy[rs_addr_i]; rt_busy_o = busy[rt_addr_i]; both combinational from registered state. busy_vec_o = busy.

Reset:
- While rst_i is high at an edge: RegWrite_o=0, RDaddr_o=0, RDdata_o=0, out_from_b=0, busy=0, wait_cnt=0.
- Reset mid-operation discards any write in the output stage. No write is issued in the cycle after reset.
- Ready outputs are combinational and remain valid during reset. Handshakes completing in a reset cycle are lost.

Optional Feature:
STARVE_EN.
- Defined: the starvation guard above is active. B waits at most STARVE_LIMIT cycles, then is granted while a_ready_o=0 for that cycle.
- Undefined: force_b is tied to 0 and wait_cnt is not instantiated. A has strict priority, and a_ready_o is constant 1.

Test Plan:
- Reset: assert rst_i 2 cycles with a_valid_i=1 -> RegWrite_o=0, busy_vec_o=0 in the cycle after release; no spurious write.
- A write: a_valid_i=1, a_addr_i=5, a_data_i=0xDEADBEEF at cycle N -> a_ready_o=1 at N; RegWrite_o=1, RDaddr_o=5, RDdata_o=0xDEADBEEF at N+1 only.
- Conflict (STARVE_EN, LIMIT=4): A and B valid continuously from cycle N -> A granted N..N+3; at N+4 b_ready_o=1, a_ready_o=0; port shows B data at N+5; A granted again at N+5.
- Scoreboard: mark 9 at N -> busy_vec_o[9]=1 and rs_busy_o=1 (rs_addr_i=9) from N+1. B write to 9 granted at M -> port write at M+1, busy[9]=0 from M+2.
- Zero register: A write to addr 0 -> a_ready_o=1, RegWrite_o stays 0; mark addr 0 -> busy_vec_o unchanged.
- Set/clear collision: B write to 9 on port in the same cycle as mark 9 -> busy[9] remains 1 afterward.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
// Write-port sharing bus for regfile_write_arbiter: two writeback requesters,
// scoreboard mark/lookup, and the register file write port.
interface regfile_write_arbiter_if;
  logic        a_valid_i;
  logic        a_ready_o;
  logic [4:0]  a_addr_i;
  logic [31:0] a_data_i;
  logic        b_valid_i;
  logic        b_ready_o;
  logic [4:0]  b_addr_i;
  logic [31:0] b_data_i;
  logic        mark_valid_i;
  logic [4:0]  mark_addr_i;
  logic [4:0]  rs_addr_i;
  logic [4:0]  rt_addr_i;
  logic        rs_busy_o;
  logic        rt_busy_o;
  logic [31:0] busy_vec_o;
  logic        RegWrite_o;
  logic [4:0]  RDaddr_o;
  logic [31:0] RDdata_o;

  modport master (
    output a_valid_i, a_addr_i, a_data_i,
    output b_valid_i, b_addr_i, b_data_i,
    output mark_valid_i, mark_addr_i, rs_addr_i, rt_addr_i,
    input  a_ready_o, b_ready_o, rs_busy_o, rt_busy_o, busy_vec_o,
    input  RegWrite_o, RDaddr_o, RDdata_o
  );

  modport slave (
    input  a_valid_i, a_addr_i, a_data_i,
    input  b_valid_i, b_addr_i, b_data_i,
    input  mark_valid_i, mark_addr_i, rs_addr_i, rt_addr_i,
    output a_ready_o, b_ready_o, rs_busy_o, rt_busy_o, busy_vec_o,
    output RegWrite_o, RDaddr_o, RDdata_o
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between writeback (A) and a long-latency
// unit (B), and tracks pending B writes. Define STARVE_EN to enable B starvation guard.
module regfile_write_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  regfile_write_arbiter_if.slave bus
);

  logic        force_b;
  logic        grant_a;
  logic        grant_b;
  logic [4:0]  win_addr;
  logic [31:0] win_data;
  logic        reg_write;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        out_from_b;
  logic [31:0] busy;
  logic [31:0] busy_next;

`ifdef STARVE_EN
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] wait_cnt;

  assign force_b = bus.b_valid_i && (wait_cnt == LIMIT);

  // Counts consecutive refused cycles of a waiting B request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_cnt <= '0;
    end else if (!bus.b_valid_i || grant_b) begin
      wait_cnt <= '0;
    end else if (wait_cnt != LIMIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  logic unused_cfg;

  assign force_b    = 1'b0;
  assign unused_cfg = ^{CNT_W[0], STARVE_LIMIT[0]};
`endif

  assign grant_a       = bus.a_valid_i && !force_b;
  assign grant_b       = bus.b_valid_i && !grant_a;
  assign bus.a_ready_o = !force_b;
  assign bus.b_ready_o = grant_b;

  assign win_addr = grant_a ? bus.a_addr_i : bus.b_addr_i;
  assign win_data = grant_a ? bus.a_data_i : bus.b_data_i;

  // Address 0 completes the handshake but never reaches the register file.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      reg_write  <= 1'b0;
      rd_addr    <= '0;
      rd_data    <= '0;
      out_from_b <= 1'b0;
    end else if (grant_a || grant_b) begin
      reg_write  <= (win_addr != 5'd0);
      rd_addr    <= win_addr;
      rd_data    <= win_data;
      out_from_b <= grant_b;
    end else begin
      reg_write  <= 1'b0;
    end
  end

  // A mark arriving while its register's B write is on the port wins.
  always_comb begin
    busy_next = busy;
    if (reg_write && out_from_b) begin
      busy_next[rd_addr] = 1'b0;
    end
    if (bus.mark_valid_i && (bus.mark_addr_i != 5'd0)) begin
      busy_next[bus.mark_addr_i] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  assign bus.rs_busy_o  = busy[bus.rs_addr_i];
  assign bus.rt_busy_o  = busy[bus.rt_addr_i];
  assign bus.busy_vec_o = busy;
  assign bus.RegWrite_o = reg_write;
  assign bus.RDaddr_o   = rd_addr;
  assign bus.RDdata_o   = rd_data;

endmodule
